shading_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational Lambert/ambient shader in the ray-marcher back end. Consumes one hit record (surface normal, light vector, hit flag) per cycle under a valid/ready handshake and emits a packed RGB pixel 3 cycles later. Adds runtime-programmable per-channel coefficients, a background colour for misses, and a normal-visualisation debug mode. Sits between the march/normal-estimation stage and the pixel stream packer.

---
 rtl/shading_pipe.sv | 161 ++++++++++++++++
 tb/tb_shading_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shading_pipe.sv
// Three-stage Lambert/ambient shader: dot product and ambient term, per-channel
// coefficient mix, then clamp/scale to packed RGB. Misses emit the background colour.
module shading_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 24,
  parameter int COEF_WIDTH = 16,
  parameter int CH_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_hit,
  input  logic signed [DATA_WIDTH-1:0] nx,
  input  logic signed [DATA_WIDTH-1:0] ny,
  input  logic signed [DATA_WIDTH-1:0] nz,
  input  logic signed [DATA_WIDTH-1:0] lx,
  input  logic signed [DATA_WIDTH-1:0] ly,
  input  logic signed [DATA_WIDTH-1:0] lz,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3*CH_WIDTH-1:0]        shade_out,
  input  logic                         cfg_we,
  input  logic [2:0]                   cfg_addr,
  input  logic [3*CH_WIDTH-1:0]        cfg_data
);

  localparam int OUT_W = 3 * CH_WIDTH;
  localparam int DOT_W = 2 * DATA_WIDTH + 2;
  localparam int V_W   = DOT_W - FRAC_BITS;
  localparam int S_W   = V_W + COEF_WIDTH + 2;

  localparam logic signed [V_W-1:0] ONE_V    = V_W'(1) <<< FRAC_BITS;
  localparam logic signed [S_W-1:0] ONE_S    = S_W'(1) <<< FRAC_BITS;
  localparam logic signed [S_W-1:0] CH_MAX_S = (S_W'(1) <<< CH_WIDTH) - S_W'(1);

  // Runtime configuration
  logic [COEF_WIDTH-1:0] amb_q  [3];
  logic [COEF_WIDTH-1:0] diff_q [3];
  logic [OUT_W-1:0]      bg_q;
  logic                  mode_q;

  // NOTE: these are a handful of flops rather than a RAM, so they take reset defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      amb_q[0]  <= COEF_WIDTH'(6553);
      amb_q[1]  <= COEF_WIDTH'(9830);
      amb_q[2]  <= COEF_WIDTH'(13107);
      diff_q[0] <= COEF_WIDTH'(26214);
      diff_q[1] <= COEF_WIDTH'(22937);
      diff_q[2] <= COEF_WIDTH'(16384);
      bg_q      <= '0;
      mode_q    <= 1'b0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0:    amb_q[0]  <= cfg_data[COEF_WIDTH-1:0];
        3'd1:    amb_q[1]  <= cfg_data[COEF_WIDTH-1:0];
        3'd2:    amb_q[2]  <= cfg_data[COEF_WIDTH-1:0];
        3'd3:    diff_q[0] <= cfg_data[COEF_WIDTH-1:0];
        3'd4:    diff_q[1] <= cfg_data[COEF_WIDTH-1:0];
        3'd5:    diff_q[2] <= cfg_data[COEF_WIDTH-1:0];
        3'd6:    bg_q      <= cfg_data;
        default: mode_q    <= cfg_data[0];
      endcase
    end
  end

  // Global stall: every stage moves together or holds together.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // S1: lighting terms (mode 0) or normal remapped to [0, ONE] (mode 1)
  logic signed [DOT_W-1:0]      dot;
  logic signed [DATA_WIDTH-1:0] amb_c;
  logic signed [V_W-1:0]        s1_v_d [3];

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    s1_v_d[0] = '0;
    s1_v_d[1] = '0;
    s1_v_d[2] = '0;
    dot   = DOT_W'(nx) * DOT_W'(lx) + DOT_W'(ny) * DOT_W'(ly) + DOT_W'(nz) * DOT_W'(lz);
    amb_c = ny[DATA_WIDTH-1] ? '0 : ny;
    if (mode_q) begin
      s1_v_d[0] = (V_W'(nx) + ONE_V) >>> 1;
      s1_v_d[1] = (V_W'(ny) + ONE_V) >>> 1;
      s1_v_d[2] = (V_W'(nz) + ONE_V) >>> 1;
    end else begin
      s1_v_d[0] = (ONE_V >>> 1) + (V_W'(amb_c) >>> 1);
      s1_v_d[1] = dot[DOT_W-1] ? '0 : V_W'(dot >>> FRAC_BITS);
    end
  end

  // S2: per-channel coefficient mix at full product precision
  logic signed [V_W-1:0] s1_v_q [3];
  logic                  s1_valid_q, s1_hit_q, s1_mode_q;
  logic signed [S_W-1:0] s2_shade_d [3];
  logic signed [S_W-1:0] mix;

  always_comb begin
    mix = '0;
    for (int c = 0; c < 3; c++) begin
      mix = S_W'(s1_v_q[0]) * S_W'($signed({1'b0, amb_q[c]}))
          + S_W'(s1_v_q[1]) * S_W'($signed({1'b0, diff_q[c]}));
      s2_shade_d[c] = s1_mode_q ? S_W'(s1_v_q[c]) : (mix >>> (COEF_WIDTH - 1));
    end
  end

  // S3: clamp and scale into CH_WIDTH-bit channels, R in the MSBs
  logic signed [S_W-1:0] s2_shade_q [3];
  logic                  s2_valid_q, s2_hit_q;
  logic [OUT_W-1:0]      shade_d;

  always_comb begin
    shade_d = bg_q;
    if (s2_hit_q) begin
      for (int c = 0; c < 3; c++) begin
        if (s2_shade_q[c][S_W-1])
          shade_d[(2-c)*CH_WIDTH +: CH_WIDTH] = '0;
        else if (s2_shade_q[c] >= ONE_S)
          shade_d[(2-c)*CH_WIDTH +: CH_WIDTH] = '1;
        else
          shade_d[(2-c)*CH_WIDTH +: CH_WIDTH] =
            CH_WIDTH'((s2_shade_q[c] * CH_MAX_S) >>> FRAC_BITS);
      end
    end
  end

  logic             out_valid_q;
  logic [OUT_W-1:0] shade_q;

  // NOTE: pipeline state uses <= so each stage captures its neighbour's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_hit_q    <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_v_q      <= '{default: '0};
      s2_valid_q  <= 1'b0;
      s2_hit_q    <= 1'b0;
      s2_shade_q  <= '{default: '0};
      out_valid_q <= 1'b0;
      shade_q     <= '0;
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      s1_hit_q    <= in_hit;
      s1_mode_q   <= mode_q;
      s1_v_q      <= s1_v_d;
      s2_valid_q  <= s1_valid_q;
      s2_hit_q    <= s1_hit_q;
      s2_shade_q  <= s2_shade_d;
      out_valid_q <= s2_valid_q;
      shade_q     <= shade_d;
    end
  end

  assign out_valid = out_valid_q;
  assign shade_out = shade_q;

endmodule

// File: tb/tb_shading_pipe.sv
// Scoreboard bench for shading_pipe: a shading model computed from plain integer
// arithmetic predicts each pixel; a monitor pops and compares on every output transfer.
module tb_shading_pipe;

  localparam int DW  = 32;
  localparam int FB  = 24;
  localparam int CW  = 16;
  localparam int CHW = 8;
  localparam int ONE = 1 << FB;

  typedef struct packed {
    logic               hit;
    logic signed [31:0] nx, ny, nz, lx, ly, lz;
  } rec_t;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, in_ready, in_hit;
  logic signed [DW-1:0] nx, ny, nz, lx, ly, lz;
  logic                 out_valid, out_ready, cfg_we;
  logic [3*CHW-1:0]     shade_out, cfg_data;
  logic [2:0]           cfg_addr;

  int          n_vec = 0;
  int          n_fail = 0;
  int          n_out = 0;
  int          ready_mode = 0;  // 0 = ready high, 1 = ready low, 2 = random
  int          cfg_amb [3];
  int          cfg_diff [3];
  logic [23:0] cfg_bg;
  logic        cfg_mode;
  logic [23:0] exp_q [$];
  bit          stall_prev = 1'b0;
  logic [23:0] prev_shade = '0;

  shading_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .COEF_WIDTH(CW), .CH_WIDTH(CHW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_hit(in_hit),
    .nx(nx), .ny(ny), .nz(nz), .lx(lx), .ly(ly), .lz(lz),
    .out_valid(out_valid), .out_ready(out_ready), .shade_out(shade_out),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_defaults();
    cfg_amb  = '{6553, 9830, 13107};
    cfg_diff = '{26214, 22937, 16384};
    cfg_bg   = 24'h0;
    cfg_mode = 1'b0;
  endtask

  // Shading model: real-number rules evaluated with 64-bit integers and floor division.
  function automatic logic [23:0] ref_pixel(input rec_t r);
    longint n [3];
    longint l [3];
    longint v [3];
    longint dot, diffuse, ambient, ch;
    logic [23:0] px;
    px = '0;
    if (!r.hit) return cfg_bg;
    n[0] = longint'($signed(r.nx)); n[1] = longint'($signed(r.ny)); n[2] = longint'($signed(r.nz));
    l[0] = longint'($signed(r.lx)); l[1] = longint'($signed(r.ly)); l[2] = longint'($signed(r.lz));
    if (cfg_mode) begin
      for (int i = 0; i < 3; i++) v[i] = (n[i] + ONE) / 2;
    end else begin
      dot     = n[0] * l[0] + n[1] * l[1] + n[2] * l[2];
      diffuse = (dot < 0) ? 0 : dot / ONE;
      ambient = ONE / 2 + ((n[1] > 0) ? n[1] : 0) / 2;
      for (int c = 0; c < 3; c++)
        v[c] = (ambient * cfg_amb[c] + diffuse * cfg_diff[c]) / (1 << (CW - 1));
    end
    for (int c = 0; c < 3; c++) begin
      if (v[c] < 0)         ch = 0;
      else if (v[c] >= ONE) ch = 255;
      else                  ch = v[c] * 255 / ONE;
      px = {px[15:0], ch[7:0]};
    end
    return px;
  endfunction

  function automatic rec_t mk(input logic h, input int ax, input int ay, input int az,
                              input int bx, input int by, input int bz);
    rec_t r;
    r.hit = h; r.nx = ax; r.ny = ay; r.nz = az; r.lx = bx; r.ly = by; r.lz = bz;
    return r;
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, 2 * ONE)) - ONE;
  endfunction

  function automatic rec_t rnd_rec(input logic h);
    return mk(h, rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
  endfunction

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compares every transfer against the scoreboard, checks stall behaviour.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_hold", {31'b0, out_valid}, 32'd1);
        check("stall_data_hold", {8'b0, shade_out}, {8'b0, prev_shade});
      end
      if (out_valid) begin
        if (!out_ready) begin
          check("in_ready_stalled", {31'b0, in_ready}, 32'd0);
        end else if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%0h, expected no output (t=%0t)", shade_out, $time);
        end else begin
          check("pixel", {8'b0, shade_out}, {8'b0, exp_q.pop_front()});
          n_out++;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_shade = shade_out;
    end
  end

  // Called aligned to posedge+1; returns aligned just after the accepting edge.
  task automatic send(input rec_t r);
    in_valid = 1'b1; in_hit = r.hit;
    nx = r.nx; ny = r.ny; nz = r.nz; lx = r.lx; ly = r.ly; lz = r.lz;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_pixel(r));
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    n_vec++;
    n_fail++;
    $display("FAIL accept_timeout: in_ready stayed 0, expected an accept within 200 cycles");
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [23:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    case (a)
      3'd0, 3'd1, 3'd2: cfg_amb[a] = int'(d[15:0]);
      3'd3, 3'd4, 3'd5: cfg_diff[a - 3'd3] = int'(d[15:0]);
      3'd6:             cfg_bg = d;
      default:          cfg_mode = d[0];
    endcase
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    n_vec++;
    n_fail++;
    $display("FAIL %s_timeout: out_valid stayed 0, expected 1 within 20 cycles", name);
  endtask

  task automatic expect_const(input string name, input rec_t r, input logic [23:0] px);
    send(r);
    in_valid = 1'b0;
    wait_valid(name);
    check(name, {8'b0, shade_out}, {8'b0, px});
    wait_drain();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_hit = 1'b0;
    nx = '0; ny = '0; nz = '0; lx = '0; ly = '0; lz = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    set_defaults();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_shade_out", {8'b0, shade_out}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // Latency: accept in cycle 0, out_valid in cycle 3
    send(mk(1'b1, 0, ONE, 0, 0, ONE, 0));
    in_valid = 1'b0;
    @(negedge clk); check("latency_c1", {31'b0, out_valid}, 32'd0);
    @(negedge clk); check("latency_c2", {31'b0, out_valid}, 32'd0);
    @(negedge clk); check("latency_c3", {31'b0, out_valid}, 32'd1);
    check("lit_up", {8'b0, shade_out}, 32'hFEFEE5);
    wait_drain();

    expect_const("back_lit", mk(1'b1, 0, ONE, 0, 0, -ONE, 0), 24'h324C65);
    cfg_write(3'd6, 24'h102030);
    expect_const("miss_bg", rnd_rec(1'b0), 24'h102030);
    cfg_write(3'd7, 24'h1);
    expect_const("miss_bg_mode1", rnd_rec(1'b0), 24'h102030);
    expect_const("normal_vis", mk(1'b1, ONE, 0, -ONE, rnd(), rnd(), rnd()), 24'hFF7F00);
    cfg_write(3'd7, 24'h0);
    cfg_write(3'd6, 24'h0);

    // Back-to-back stream with a 5-cycle output stall
    n_out = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rnd_rec(1'b1));
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        ready_mode = 1;
        repeat (5) @(posedge clk);
        ready_mode = 0;
      end
    join
    wait_drain();
    check("stream_count", n_out, 32'd8);

    // Randomised configs, hit/miss mix, input gaps and random backpressure
    for (int round = 0; round < 4; round++) begin
      for (int c = 0; c < 3; c++) begin
        cfg_write(3'(c), 24'($urandom_range(0, 65535)));
        cfg_write(3'(c + 3), 24'($urandom_range(0, 65535)));
      end
      cfg_write(3'd6, 24'($urandom));
      cfg_write(3'd7, 24'(round % 2));
      ready_mode = 2;
      for (int i = 0; i < 25; i++) begin
        send(rnd_rec($urandom_range(0, 3) != 0));
        if ($urandom_range(0, 4) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b0;
      ready_mode = 0;
      wait_drain();
    end
    cfg_write(3'd7, 24'h0);

    // Reset with three records in flight; a config write during reset is ignored
    cfg_write(3'd0, 24'h0);
    ready_mode = 1;
    for (int i = 0; i < 3; i++) send(rnd_rec(1'b1));
    rst = 1'b1;
    #1;
    check("rst_flush_valid", {31'b0, out_valid}, 32'd0);
    exp_q.delete();
    set_defaults();
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd6; cfg_data = 24'hABCDEF;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    rst = 1'b0;
    ready_mode = 0;
    repeat (6) begin
      @(negedge clk);
      check("no_stale_output", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    expect_const("post_rst_default", mk(1'b1, 0, ONE, 0, 0, ONE, 0), 24'hFEFEE5);
    expect_const("post_rst_bg", rnd_rec(1'b0), 24'h000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
